// File: rtl/cpu_jtag_scan_master.sv
// Virtual-JTAG scan initiator: turns one IR+DR command into a UIR, CDR, SHIFT, UDR, RTI
// sequence on a generated tck and returns the captured tdo bits.
module cpu_jtag_scan_master #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int CNT_W = $clog2(DR_WIDTH + 1);
  localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);

  // Strobe vector bit order: {uir, cdr, sdr, udr, rti}
  localparam logic [4:0] STB_UIR = 5'b10000;
  localparam logic [4:0] STB_CDR = 5'b01000;
  localparam logic [4:0] STB_SDR = 5'b00100;
  localparam logic [4:0] STB_UDR = 5'b00010;
  localparam logic [4:0] STB_RTI = 5'b00001;

  typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SHIFT, S_UDR, S_RTI} state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic                 tck_q, tck_d;
  logic                 tdi_q, tdi_d;
  logic [IR_WIDTH-1:0]  ir_in_q, ir_in_d;
  logic [4:0]           stb_q, stb_d;
  logic [DR_WIDTH-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DR_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic [IR_WIDTH-1:0]  rsp_ir_out_q, rsp_ir_out_d;

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    tck_d        = tck_q;
    tdi_d        = tdi_q;
    ir_in_d      = ir_in_q;
    stb_d        = stb_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    rsp_ir_out_d = rsp_ir_out_q;

    if (state_q == S_IDLE) begin
      if (cmd_valid) begin
        ir_in_d   = cmd_ir;
        shift_d   = cmd_data;
        state_d   = S_UIR;
        stb_d     = STB_UIR;
        div_cnt_d = '0;
        tck_d     = 1'b0;
      end
    end else if (div_cnt_q != DIV_LAST) begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end else begin
      div_cnt_d = '0;
      if (!tck_q) begin
        // Rising tck: responder-side sampling points
        tck_d = 1'b1;
        if (state_q == S_UIR) rsp_ir_out_d = vji_ir_out;
        if (state_q == S_SHIFT) begin
          shift_d   = {vji_tdo, shift_q[DR_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end
      end else begin
        // Falling tck: all state, strobe and tdi changes happen here
        tck_d = 1'b0;
        case (state_q)
          S_UIR: begin
            state_d = S_CDR;
            stb_d   = STB_CDR;
          end
          S_CDR: begin
            state_d   = S_SHIFT;
            stb_d     = STB_SDR;
            bit_cnt_d = CNT_W'(DR_WIDTH);
            tdi_d     = shift_q[0];
          end
          S_SHIFT: begin
            if (bit_cnt_q == '0) begin
              state_d = S_UDR;
              stb_d   = STB_UDR;
              tdi_d   = 1'b0;
            end else begin
              tdi_d = shift_q[0];
            end
          end
          S_UDR: begin
            state_d = S_RTI;
            stb_d   = STB_RTI;
          end
          default: begin
            state_d     = S_IDLE;
            stb_d       = '0;
            rsp_data_d  = shift_q;
            rsp_valid_d = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      div_cnt_q    <= '0;
      tck_q        <= 1'b0;
      tdi_q        <= 1'b0;
      ir_in_q      <= '0;
      stb_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_ir_out_q <= '0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      tck_q        <= tck_d;
      tdi_q        <= tdi_d;
      ir_in_q      <= ir_in_d;
      stb_q        <= stb_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_ir_out_q <= rsp_ir_out_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q   <= shift_d;
    bit_cnt_q <= bit_cnt_d;
  end

  assign cmd_ready  = (state_q == S_IDLE) && !reset;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_ir_out = rsp_ir_out_q;
  assign vji_tck    = tck_q;
  assign vji_tdi    = tdi_q;
  assign vji_ir_in  = ir_in_q;
  assign vji_uir    = stb_q[4];
  assign vji_cdr    = stb_q[3];
  assign vji_sdr    = stb_q[2];
  assign vji_udr    = stb_q[1];
  assign vji_rti    = stb_q[0];

endmodule
